// File: rtl/rnd_unit.sv
// rnd_unit: samples an upstream random byte into a small FIFO and
// serves masked values to CPU RND (Cxkk) requests over valid/ready.
module rnd_unit #(
  parameter int SAMPLE_DIV = 8,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               random_byte,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [7:0]               req_mask,
  input  logic [3:0]               req_reg,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [7:0]               resp_data,
  output logic [3:0]               resp_reg,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0]    LAST = 8'(SAMPLE_DIV - 1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [7:0]    cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    mem [DEPTH];
  logic          sample;
  logic          push;
  logic          pop;

  assign sample    = (cnt == LAST);
  assign req_ready = (level != '0) && (!resp_valid || resp_ready);
  assign pop       = req_valid && req_ready;
  // a full FIFO still takes the sample if its head leaves on the same edge
  assign push      = sample && ((level != FULL) || pop);

  // free-running sample divider
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (sample) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  // sample storage; entries only become readable after being written
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= random_byte;
    end
  end

  // circular pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // response register: load on accept, clear valid on handoff, else hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_data  <= 8'h00;
      resp_reg   <= 4'h0;
    end else if (pop) begin
      resp_valid <= 1'b1;
      resp_data  <= mem[rd_ptr] & req_mask;
      resp_reg   <= req_reg;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule
